// File: rtl/epu_loader_if.sv
// Host register port and verification-unit handshake of epu_loader, bundled.
// The master modport is the side that drives writes, start, ready and result.
interface epu_loader_if;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         cmd_start;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic         wr_err;
    logic [511:0] sig;
    logic [255:0] key;
    logic [255:0] rhash;
    logic         valid;
    logic         ready;
    logic         result;

    modport master (
        output wr_en, wr_addr, wr_data, cmd_start, ready, result,
        input  busy, done, pass, timeout, wr_err, sig, key, rhash, valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, cmd_start, ready, result,
        output busy, done, pass, timeout, wr_err, sig, key, rhash, valid
    );
endinterface

// File: rtl/epu_loader.sv
// Loads signature/key/hash operands and runs one job on the verification unit.
// Optional job timeout is compiled in with EPU_LOADER_TIMEOUT_EN.
module epu_loader #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic         axiclk,
    input  logic         resetn,
    epu_loader_if.slave  bus
);

    // state   | meaning
    // IDLE    | operands writable, waiting for cmd_start
    // ARM     | waiting for the unit to report ready
    // ISSUE   | valid high for this cycle only
    // ACK     | waiting for the unit to drop ready
    // WAIT    | waiting for ready to return with a result
    // DONE    | done pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ISSUE, S_ACK, S_WAIT, S_DONE
    } state_t;

    state_t state;

    always_ff @(posedge axiclk or negedge resetn) begin
        if (!resetn) begin
            bus.sig   <= '0;
            bus.key   <= '0;
            bus.rhash <= '0;
        end else if (bus.wr_en && state == S_IDLE) begin
            if (!bus.wr_addr[4])
                bus.sig[{bus.wr_addr[3:0], 5'd0} +: 32] <= bus.wr_data;
            else if (!bus.wr_addr[3])
                bus.key[{bus.wr_addr[2:0], 5'd0} +: 32] <= bus.wr_data;
            else
                bus.rhash[{bus.wr_addr[2:0], 5'd0} +: 32] <= bus.wr_data;
        end
    end

`ifdef EPU_LOADER_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic [23:0] tmo_next;
    logic        tmo_hit;

    assign tmo_hit  = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
    assign tmo_next = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 24'd1;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign bus.timeout    = 1'b0;
`endif

    always_ff @(posedge axiclk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.pass   <= 1'b0;
            bus.wr_err <= 1'b0;
            bus.valid  <= 1'b0;
`ifdef EPU_LOADER_TIMEOUT_EN
            bus.timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            bus.done  <= 1'b0;
            bus.valid <= 1'b0;
            if (bus.wr_en && bus.busy)
                bus.wr_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.cmd_start) begin
                        bus.busy   <= 1'b1;
                        bus.pass   <= 1'b0;
                        bus.wr_err <= 1'b0;
`ifdef EPU_LOADER_TIMEOUT_EN
                        bus.timeout <= 1'b0;
`endif
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (bus.ready) begin
                        bus.valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef EPU_LOADER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= S_ACK;
                end
                S_ACK: begin
`ifdef EPU_LOADER_TIMEOUT_EN
                    if (tmo_hit) begin
                        bus.timeout <= 1'b1;
                        bus.pass    <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (!bus.ready)
                            state <= S_WAIT;
                    end
`else
                    if (!bus.ready)
                        state <= S_WAIT;
`endif
                end
                S_WAIT: begin
                    // A completion seen on the last allowed cycle beats the timeout.
                    if (bus.ready) begin
                        bus.pass <= bus.result;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end
`ifdef EPU_LOADER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        bus.timeout <= 1'b1;
                        bus.pass    <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epu_loader.sv
// Directed/randomized bench for epu_loader with a behavioural operand and
// verification-unit model; expected job timing is derived from the ready waveform.
module tb_epu_loader;
    localparam logic [23:0] TMO = 24'd100;

    logic axiclk = 1'b0;
    logic resetn = 1'b0;

    epu_loader_if bus ();

    epu_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .axiclk (axiclk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 axiclk = ~axiclk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_done = 0;
    int valid_cyc = -1;
    int done_cyc = -1;

    logic drop_pending = 1'b0;
    int   low_left = 0;
    int   unit_lat = 50;
    logic unit_res = 1'b1;
    logic unit_hang = 1'b0;

    logic [31:0] words [32];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_sig();
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = words[k];
        return r;
    endfunction

    function automatic logic [255:0] exp_key();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = words[16+k];
        return r;
    endfunction

    function automatic logic [255:0] exp_rhash();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = words[24+k];
        return r;
    endfunction

    // One cycle: sample outputs mid-cycle, then advance the verification-unit model.
    task automatic tick();
        @(negedge axiclk);
        cyc++;
        if (bus.valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (drop_pending) begin
            bus.ready    = 1'b0;
            drop_pending = 1'b0;
            low_left     = unit_lat;
        end else if (low_left > 0) begin
            low_left--;
            if (low_left == 0 && !unit_hang) begin
                bus.ready  = 1'b1;
                bus.result = unit_res;
            end
        end
        if (bus.valid) drop_pending = 1'b1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_job(output int t);
        t = cyc;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n0;
        n0 = n_done;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != n0) break;
        end
        ok = (n_done != n0);
    endtask

    task automatic reset_unit();
        bus.ready    = 1'b1;
        bus.result   = 1'b0;
        drop_pending = 1'b0;
        low_left     = 0;
        unit_hang    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   bus.busy,   1'b0);
        check({tag, "_done"},   bus.done,   1'b0);
        check({tag, "_pass"},   bus.pass,   1'b0);
        check({tag, "_tmo"},    bus.timeout, 1'b0);
        check({tag, "_wr_err"}, bus.wr_err, 1'b0);
        check({tag, "_valid"},  bus.valid,  1'b0);
        check({tag, "_sig"},    bus.sig,    512'b0);
        check({tag, "_key"},    bus.key,    256'b0);
        check({tag, "_rhash"},  bus.rhash,  256'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int nv0;
        int nd0;
        int r;
        bit ok;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] w3;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cmd_start = 1'b0;
        reset_unit();
        for (int i = 0; i < 32; i++) words[i] = '0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Write mapping
        do_write(5'd0,  32'hDEADBEEF); words[0]  = 32'hDEADBEEF;
        do_write(5'd15, 32'h12345678); words[15] = 32'h12345678;
        do_write(5'd16, 32'hA5A5A5A5); words[16] = 32'hA5A5A5A5;
        do_write(5'd31, 32'h01020304); words[31] = 32'h01020304;
        check("map_sig_lo",   bus.sig[31:0],      32'hDEADBEEF);
        check("map_sig_hi",   bus.sig[511:480],   32'h12345678);
        check("map_key_lo",   bus.key[31:0],      32'hA5A5A5A5);
        check("map_rhash_hi", bus.rhash[255:224], 32'h01020304);
        check("map_sig",   bus.sig,   exp_sig());
        check("map_key",   bus.key,   exp_key());
        check("map_rhash", bus.rhash, exp_rhash());

        // Random writes in IDLE
        for (int i = 0; i < 24; i++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            do_write(a, d);
            words[a] = d;
        end
        check("rnd_sig",   bus.sig,   exp_sig());
        check("rnd_key",   bus.key,   exp_key());
        check("rnd_rhash", bus.rhash, exp_rhash());

        // Pass job, with a write in the same cycle as the start
        unit_lat = 50; unit_res = 1'b1;
        nv0 = n_valid;
        a = 5'($urandom_range(0, 31));
        d = $urandom;
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        words[a] = d;
        start_job(t);
        bus.wr_en = 1'b0;
        check("pass_busy_up", bus.busy, 1'b1);
        wait_done(300, ok);
        check("pass_done_seen", ok, 1'b1);
        check("pass_valid_cyc", valid_cyc, t + 2);
        check("pass_valid_cnt", n_valid - nv0, 1);
        check("pass_done_cyc", done_cyc, valid_cyc + unit_lat + 2);
        check("pass_verdict", bus.pass, 1'b1);
        check("pass_busy_down", bus.busy, 1'b0);
        check("pass_tmo", bus.timeout, 1'b0);
        tick();
        check("pass_done_pulse", bus.done, 1'b0);
        check("pass_hold", bus.pass, 1'b1);
        check("pass_sig",   bus.sig,   exp_sig());
        check("pass_key",   bus.key,   exp_key());
        check("pass_rhash", bus.rhash, exp_rhash());

        // Fail job with a write while busy
        unit_lat = 50; unit_res = 1'b0;
        start_job(t);
        check("fail_pass_cleared", bus.pass, 1'b0);
        repeat (10) tick();
        w3 = ~words[3];
        do_write(5'd3, w3);
        check("fail_wr_err", bus.wr_err, 1'b1);
        wait_done(300, ok);
        check("fail_done_seen", ok, 1'b1);
        check("fail_done_cyc", done_cyc, valid_cyc + unit_lat + 2);
        check("fail_verdict", bus.pass, 1'b0);
        check("fail_wr_err_held", bus.wr_err, 1'b1);
        check("fail_sig_word3", bus.sig[127:96], words[3]);
        check("fail_sig", bus.sig, exp_sig());
        tick();

        // Next start clears wr_err
        unit_lat = 5; unit_res = 1'b1;
        start_job(t);
        check("clr_wr_err", bus.wr_err, 1'b0);
        wait_done(100, ok);
        check("clr_done_seen", ok, 1'b1);
        check("clr_verdict", bus.pass, 1'b1);
        tick();

        // Deferred issue
        bus.ready = 1'b0;
        unit_lat = 8; unit_res = 1'b1;
        nv0 = n_valid;
        start_job(t);
        repeat (19) tick();
        check("defer_no_valid", n_valid - nv0, 0);
        check("defer_busy", bus.busy, 1'b1);
        r = cyc;
        bus.ready = 1'b1;
        wait_done(100, ok);
        check("defer_done_seen", ok, 1'b1);
        check("defer_valid_cyc", valid_cyc, r + 1);
        check("defer_valid_cnt", n_valid - nv0, 1);
        check("defer_done_cyc", done_cyc, valid_cyc + unit_lat + 2);
        tick();

        // Unit never completes
        unit_hang = 1'b1; unit_lat = 3;
        nd0 = n_done;
        start_job(t);
`ifdef EPU_LOADER_TIMEOUT_EN
        wait_done(400, ok);
        check("tmo_done_seen", ok, 1'b1);
        check("tmo_done_cyc", done_cyc, valid_cyc + 1 + int'(TMO));
        check("tmo_flag", bus.timeout, 1'b1);
        check("tmo_pass", bus.pass, 1'b0);
        check("tmo_busy", bus.busy, 1'b0);
        tick();
        reset_unit();
        unit_lat = 4; unit_res = 1'b1;
        start_job(t);
        check("tmo_cleared", bus.timeout, 1'b0);
        wait_done(100, ok);
        check("tmo_recover_done", ok, 1'b1);
        check("tmo_recover_pass", bus.pass, 1'b1);
        tick();
`else
        repeat (1000) tick();
        check("notmo_no_done", n_done - nd0, 0);
        check("notmo_busy", bus.busy, 1'b1);
        check("notmo_tmo", bus.timeout, 1'b0);
        resetn = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) words[i] = '0;
        reset_unit();
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            do_write(a, d);
            words[a] = d;
        end
`endif

        // Reset in the middle of a job
        unit_hang = 1'b0; unit_lat = 200; unit_res = 1'b1;
        start_job(t);
        repeat (30) tick();
        check("rst_pre_busy", bus.busy, 1'b1);
        nd0 = n_done;
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_async");
        for (int i = 0; i < 32; i++) words[i] = '0;
        reset_unit();
        repeat (3) tick();
        check("rst_no_done", n_done - nd0, 0);
        resetn = 1'b1;
        tick();
        a = 5'($urandom_range(0, 31));
        d = $urandom;
        do_write(a, d);
        words[a] = d;
        unit_lat = 3; unit_res = 1'b1;
        nv0 = n_valid;
        start_job(t);
        wait_done(100, ok);
        check("post_rst_done", ok, 1'b1);
        check("post_rst_valid_cyc", valid_cyc, t + 2);
        check("post_rst_valid_cnt", n_valid - nv0, 1);
        check("post_rst_pass", bus.pass, 1'b1);
        check("post_rst_sig",   bus.sig,   exp_sig());
        check("post_rst_key",   bus.key,   exp_key());
        check("post_rst_rhash", bus.rhash, exp_rhash());
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
